dm_abstract_cmd: RTL and testbench
==================================

DM_ABSTRACT_CMD -- requirements
Module: dm_abstract_cmd

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: max cycles dm_reg_rd_wr_en_o stays high awaiting ack.
REQ-002 SHALL have ports, clock and reset first:
- clk_i  input  1  sole clock.
- reset_i  input  1  synchronous, active-low reset.
- cmd_valid_i  input  1  one-cycle strobe: DMI write to command register.
- cmd_i  input  32  abstract command: [31:24] cmdtype, [22:20] aarsize, [18] postexec, [17] transfer, [16] write, [15:0] regno.
- data0_wr_en_i  input  1  DMI write strobe to data0.
- data0_wdata_i  input  32  DMI write data for data0.
- cmderr_clr_i  input  3  write-1-to-clear mask for cmderr, one-cycle.
- hart_halted_i  input  1  hart is in debug mode.
- dm_reg_rdata_i  input  32  register read data, valid with ack.
- dm_reg_ack_i  input  1  register access complete.
- data0_o  output  32  data0 register.
- busy_o  output  1  command in progress.
- cmderr_o  output  3  sticky command error.
- dm_reg_rd_wr_en_o  output  1  register access request.
- dm_reg_rd_wr_o  output  1  1 = write, 0 = read.
- dm_reg_rd_wr_address_o  output  16  regno of access.
- dm_reg_wdata_o  output  32  write data, equals data0.

Function
REQ-003 FSM states SHALL be IDLE, CHECK, ACCESS, DONE.
REQ-004 IDLE with cmd_valid_i=1 and cmderr_o=0 SHALL latch cmd_i and go to CHECK; busy_o=1 from the next cycle.
REQ-005 cmd_valid_i=1 while cmderr_o!=0 SHALL be ignored without state change.
REQ-006 CHECK SHALL set cmderr by priority and go to DONE:
- hart_halted_i=0 -> 4 (haltresume).
- cmdtype!=0, postexec=1, or transfer=1 with aarsize!=2 -> 2 (notsupported).
- transfer=1 with regno>=0x1020 -> 3 (exception).
REQ-007 CHECK with transfer=0 and no error SHALL go to DONE with no register access.
REQ-008 Otherwise CHECK SHALL go to ACCESS.
REQ-009 ACCESS SHALL hold dm_reg_rd_wr_en_o=1, dm_reg_rd_wr_o=write, address=regno and wdata=data0 until dm_reg_ack_i=1, then go to DONE.
REQ-010 On ack of a read, data0 SHALL load dm_reg_rdata_i in the same clock edge.
REQ-011 An 8-bit counter SHALL count ACCESS cycles; reaching TIMEOUT_CYCLES without ack SHALL drop en, set cmderr=3, go to DONE, and leave data0 unchanged.
REQ-012 DONE SHALL last one cycle with busy_o=1, then go to IDLE; busy_o=0 in IDLE.
REQ-013 Minimum latency from cmd_valid_i to en SHALL be 2 cycles, with ack in the first ACCESS cycle honoured.
REQ-014 cmd_valid_i or data0_wr_en_i while busy_o=1 SHALL be ignored and SHALL set cmderr=1 if cmderr was 0.
REQ-015 data0_wr_en_i while idle SHALL load data0_wdata_i next edge.
REQ-016 Bits set in cmderr_clr_i SHALL clear cmderr bits.
REQ-017 A same-cycle error set SHALL win over clear.
REQ-018 dm_reg_rd_wr_en_o SHALL be 0 in every state except ACCESS.
REQ-019 dm_reg_ack_i outside ACCESS SHALL be ignored.

Reset
REQ-020 reset_i=0 at a clock edge SHALL force IDLE and zero data0_o, cmderr_o, busy_o, the latched command and the counter.
REQ-021 reset_i=0 at a clock edge SHALL deassert all dm_reg_* outputs, including mid-ACCESS, with no data0 update.

Structure
REQ-022 Package dm_pkg SHALL hold:
- state enum.
- cmderr enum: NONE=0, BUSY=1, NOTSUP=2, EXCEPT=3, HALTRESUME=4.
- command field bit positions.
- GPR base 0x1000.
- regno limit 0x1020.
- AARSIZE_32=2.
REQ-023 Command legality checks SHALL live in one combinational sub-module, dm_cmd_decode, instantiated once.

Verification
REQ-024 Halted, data0=0xDEADBEEF, cmd 0x00230300 -> en write cycle 2, address 0x0300, wdata 0xDEADBEEF; ack -> busy low 2 cycles later, cmderr 0.
REQ-025 Halted, cmd 0x00221005, ack with rdata 0x12345678 -> data0_o=0x12345678, cmderr 0.
REQ-026 Hart not halted, cmd 0x00221005 -> no en, cmderr 4; next cmd ignored until cmderr_clr_i=3'b111.
REQ-027 Second cmd_valid_i during ACCESS -> cmderr 1, first access completes; cmd with aarsize=3 -> cmderr 2, no en.
REQ-028 TIMEOUT_CYCLES=4, no ack -> en high exactly 4 cycles, then cmderr 3, data0 unchanged.
REQ-029 reset_i low during ACCESS -> en 0, busy 0, data0 0 next cycle; a late ack is ignored.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and constants for the debug-module abstract command block.
// Command field positions, error codes and FSM states.
package dm_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_ACCESS,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_BUSY       = 3'd1,
    ERR_NOTSUP     = 3'd2,
    ERR_EXCEPT     = 3'd3,
    ERR_HALTRESUME = 3'd4
  } cmderr_e;

  localparam int CMDTYPE_HI   = 31;
  localparam int CMDTYPE_LO   = 24;
  localparam int AARSIZE_HI   = 22;
  localparam int AARSIZE_LO   = 20;
  localparam int POSTEXEC_BIT = 18;
  localparam int TRANSFER_BIT = 17;
  localparam int WRITE_BIT    = 16;
  localparam int REGNO_HI     = 15;
  localparam int REGNO_LO     = 0;

  localparam logic [15:0] GPR_BASE    = 16'h1000;
  localparam logic [15:0] REGNO_LIMIT = GPR_BASE + 16'h0020;
  localparam logic [2:0]  AARSIZE_32  = 3'd2;

endpackage

// File: rtl/dm_cmd_decode.sv
// Legality check of a latched abstract command.
// Yields the error to raise (or none) and whether a transfer is wanted.
module dm_cmd_decode
  import dm_pkg::*;
(
  input  logic [31:0] cmd_i,
  input  logic        hart_halted_i,
  output cmderr_e     err_o,
  output logic        transfer_o
);

  logic [7:0]  cmdtype;
  logic [2:0]  aarsize;
  logic        postexec;
  logic        transfer;
  logic [15:0] regno;
  logic        ns_raw;
  logic        ex_raw;
  logic        c_halt;
  logic        c_ns;
  logic        c_ex;
  logic        unused_bits;

  assign cmdtype  = cmd_i[CMDTYPE_HI:CMDTYPE_LO];
  assign aarsize  = cmd_i[AARSIZE_HI:AARSIZE_LO];
  assign postexec = cmd_i[POSTEXEC_BIT];
  assign transfer = cmd_i[TRANSFER_BIT];
  assign regno    = cmd_i[REGNO_HI:REGNO_LO];

  assign unused_bits = ^{cmd_i[23], cmd_i[19], cmd_i[WRITE_BIT]};

  assign ns_raw = (cmdtype != 8'd0) || postexec
                || (transfer && aarsize != AARSIZE_32);
  assign ex_raw = transfer && (regno >= REGNO_LIMIT);

  // Priority folded into mutually exclusive terms
  assign c_halt = !hart_halted_i;
  assign c_ns   = hart_halted_i && ns_raw;
  assign c_ex   = hart_halted_i && !ns_raw && ex_raw;

  always_comb begin
    err_o = ERR_NONE;
    unique case (1'b1)
      c_halt:  err_o = ERR_HALTRESUME;
      c_ns:    err_o = ERR_NOTSUP;
      c_ex:    err_o = ERR_EXCEPT;
      default: err_o = ERR_NONE;
    endcase
  end

  assign transfer_o = transfer;

endmodule

// File: rtl/dm_abstract_cmd.sv
// Abstract command engine: accepts a DMI command, checks it and
// performs one register access through the dm_reg handshake.
module dm_abstract_cmd
  import dm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cmd_valid_i,
  input  logic [31:0] cmd_i,
  input  logic        data0_wr_en_i,
  input  logic [31:0] data0_wdata_i,
  input  logic [2:0]  cmderr_clr_i,
  input  logic        hart_halted_i,
  input  logic [31:0] dm_reg_rdata_i,
  input  logic        dm_reg_ack_i,
  output logic [31:0] data0_o,
  output logic        busy_o,
  output logic [2:0]  cmderr_o,
  output logic        dm_reg_rd_wr_en_o,
  output logic        dm_reg_rd_wr_o,
  output logic [15:0] dm_reg_rd_wr_address_o,
  output logic [31:0] dm_reg_wdata_o
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

  state_e      state_q;
  state_e      state_d;
  logic [31:0] cmd_q;
  logic [31:0] data0_q;
  logic [2:0]  cmderr_q;
  logic [2:0]  cmderr_d;
  logic [7:0]  cnt_q;
  cmderr_e     dec_err;
  logic        dec_xfer;
  cmderr_e     fsm_err;
  logic        fsm_err_set;
  logic        in_access;
  logic        busy;
  logic        accept;
  logic        busy_err;
  logic        timeout;
  logic        rd_ack;

  dm_cmd_decode u_dec (
    .cmd_i         (cmd_q),
    .hart_halted_i (hart_halted_i),
    .err_o         (dec_err),
    .transfer_o    (dec_xfer)
  );

  assign in_access = (state_q == S_ACCESS);
  assign busy      = (state_q != S_IDLE);
  assign accept    = !busy && cmd_valid_i && (cmderr_q == 3'd0);
  assign busy_err  = busy && (cmd_valid_i || data0_wr_en_i)
                   && (cmderr_q == 3'd0);
  assign timeout   = in_access && !dm_reg_ack_i
                   && (8'(cnt_q + 8'd1) == TO_LIM);
  assign rd_ack    = in_access && dm_reg_ack_i && !cmd_q[WRITE_BIT];

  always_comb begin
    state_d     = state_q;
    fsm_err     = ERR_NONE;
    fsm_err_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (dec_err != ERR_NONE) begin
          fsm_err     = dec_err;
          fsm_err_set = 1'b1;
          state_d     = S_DONE;
        end else if (!dec_xfer) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (dm_reg_ack_i) begin
          state_d = S_DONE;
        end else if (timeout) begin
          fsm_err     = ERR_EXCEPT;
          fsm_err_set = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Any error raised this cycle beats a concurrent clear
  always_comb begin
    cmderr_d = cmderr_q & ~cmderr_clr_i;
    if (fsm_err_set) cmderr_d = fsm_err;
    else if (busy_err) cmderr_d = ERR_BUSY;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      data0_q  <= '0;
      cmderr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cmderr_q <= cmderr_d;
      if (accept) cmd_q <= cmd_i;
      cnt_q <= in_access ? 8'(cnt_q + 8'd1) : 8'd0;
      if (rd_ack) data0_q <= dm_reg_rdata_i;
      else if (!busy && data0_wr_en_i) data0_q <= data0_wdata_i;
    end
  end

  assign data0_o                = data0_q;
  assign busy_o                 = busy;
  assign cmderr_o               = cmderr_q;
  assign dm_reg_rd_wr_en_o      = in_access;
  assign dm_reg_rd_wr_o         = in_access && cmd_q[WRITE_BIT];
  assign dm_reg_rd_wr_address_o = in_access ? cmd_q[REGNO_HI:REGNO_LO] : 16'h0;
  assign dm_reg_wdata_o         = data0_q;

endmodule

// File: tb/tb_dm_abstract_cmd.sv
// Directed bench for dm_abstract_cmd: vector table of single commands
// plus hand sequences for busy error, timeout and mid-access reset.
module tb_dm_abstract_cmd;

  logic        clk;
  logic        reset_i;
  logic        cmd_valid_i;
  logic [31:0] cmd_i;
  logic        data0_wr_en_i;
  logic [31:0] data0_wdata_i;
  logic [2:0]  cmderr_clr_i;
  logic        hart_halted_i;
  logic [31:0] dm_reg_rdata_i;
  logic        dm_reg_ack_i;
  logic [31:0] data0_o;
  logic        busy_o;
  logic [2:0]  cmderr_o;
  logic        en;
  logic        wr;
  logic [15:0] addr;
  logic [31:0] wdata;

  int checks;
  int failures;

  dm_abstract_cmd #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i                  (clk),
    .reset_i                (reset_i),
    .cmd_valid_i            (cmd_valid_i),
    .cmd_i                  (cmd_i),
    .data0_wr_en_i          (data0_wr_en_i),
    .data0_wdata_i          (data0_wdata_i),
    .cmderr_clr_i           (cmderr_clr_i),
    .hart_halted_i          (hart_halted_i),
    .dm_reg_rdata_i         (dm_reg_rdata_i),
    .dm_reg_ack_i           (dm_reg_ack_i),
    .data0_o                (data0_o),
    .busy_o                 (busy_o),
    .cmderr_o               (cmderr_o),
    .dm_reg_rd_wr_en_o      (en),
    .dm_reg_rd_wr_o         (wr),
    .dm_reg_rd_wr_address_o (addr),
    .dm_reg_wdata_o         (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d0;
    logic        halted;
    logic [31:0] cmd;
    logic [31:0] rdata;
    logic        exp_en;
    logic        exp_wr;
    logic [31:0] exp_d0;
    logic [2:0]  exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic load_d0(input logic [31:0] v);
    data0_wr_en_i = 1'b1;
    data0_wdata_i = v;
    tick();
    data0_wr_en_i = 1'b0;
    chk("data0_load", data0_o, v);
  endtask

  task automatic clear_err();
    cmderr_clr_i = 3'b111;
    tick();
    cmderr_clr_i = 3'b000;
    chk("cmderr_cleared", {29'd0, cmderr_o}, 32'd0);
  endtask

  task automatic issue(input logic [31:0] c);
    cmd_valid_i = 1'b1;
    cmd_i       = c;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_i = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_i = '0;
    data0_wr_en_i = 1'b0;
    data0_wdata_i = '0;
    cmderr_clr_i = '0;
    hart_halted_i = 1'b1;
    dm_reg_rdata_i = '0;
    dm_reg_ack_i = 1'b0;

    //             d0            halt cmd           rdata         en wr exp_d0        err
    vecs[0]  = '{32'hDEADBEEF, 1'b1, 32'h00230300, 32'h0,        1, 1, 32'hDEADBEEF, 3'd0};
    vecs[1]  = '{32'h00000000, 1'b1, 32'h00221005, 32'h12345678, 1, 0, 32'h12345678, 3'd0};
    vecs[2]  = '{32'hA5A5A5A5, 1'b0, 32'h00221005, 32'h0,        0, 0, 32'hA5A5A5A5, 3'd4};
    vecs[3]  = '{32'h0000FFFF, 1'b1, 32'h00331005, 32'h0,        0, 0, 32'h0000FFFF, 3'd2};
    vecs[4]  = '{32'h00000001, 1'b1, 32'h01221005, 32'h0,        0, 0, 32'h00000001, 3'd2};
    vecs[5]  = '{32'h00000002, 1'b1, 32'h00261005, 32'h0,        0, 0, 32'h00000002, 3'd2};
    vecs[6]  = '{32'h00000003, 1'b1, 32'h00221020, 32'h0,        0, 0, 32'h00000003, 3'd3};
    vecs[7]  = '{32'h00000004, 1'b1, 32'h0022101F, 32'hCAFEF00D, 1, 0, 32'hCAFEF00D, 3'd0};
    vecs[8]  = '{32'h00000005, 1'b1, 32'h00300000, 32'h0,        0, 0, 32'h00000005, 3'd0};
    vecs[9]  = '{32'h00000006, 1'b1, 32'h00002000, 32'h0,        0, 0, 32'h00000006, 3'd0};
    vecs[10] = '{32'h00000007, 1'b0, 32'h00331005, 32'h0,        0, 0, 32'h00000007, 3'd4};
    vecs[11] = '{32'h00000008, 1'b1, 32'h00331020, 32'h0,        0, 0, 32'h00000008, 3'd2};

    tick();
    tick();
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_data0", data0_o, 32'd0);
    chk("rst_cmderr", {29'd0, cmderr_o}, 32'd0);
    chk("rst_en", {31'd0, en}, 32'd0);
    reset_i = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      load_d0(vecs[i].d0);
      hart_halted_i = vecs[i].halted;
      issue(vecs[i].cmd);
      chk($sformatf("v%0d_busy_c1", i), {31'd0, busy_o}, 32'd1);
      chk($sformatf("v%0d_en_c1", i), {31'd0, en}, 32'd0);
      tick();
      chk($sformatf("v%0d_en_c2", i), {31'd0, en}, {31'd0, vecs[i].exp_en});
      if (vecs[i].exp_en) begin
        chk($sformatf("v%0d_wr", i), {31'd0, wr}, {31'd0, vecs[i].exp_wr});
        chk($sformatf("v%0d_addr", i), {16'd0, addr}, {16'd0, vecs[i].cmd[15:0]});
        chk($sformatf("v%0d_wdata", i), wdata, vecs[i].d0);
        dm_reg_ack_i = 1'b1;
        dm_reg_rdata_i = vecs[i].rdata;
        tick();
        dm_reg_ack_i = 1'b0;
        chk($sformatf("v%0d_busy_done", i), {31'd0, busy_o}, 32'd1);
        chk($sformatf("v%0d_en_done", i), {31'd0, en}, 32'd0);
        tick();
      end else begin
        chk($sformatf("v%0d_busy_c2", i), {31'd0, busy_o}, 32'd1);
        tick();
      end
      chk($sformatf("v%0d_idle", i), {31'd0, busy_o}, 32'd0);
      chk($sformatf("v%0d_cmderr", i), {29'd0, cmderr_o}, {29'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_data0", i), data0_o, vecs[i].exp_d0);
      if (vecs[i].exp_err != 3'd0) begin
        hart_halted_i = 1'b1;
        issue(32'h00230300);
        chk($sformatf("v%0d_ignored", i), {31'd0, busy_o}, 32'd0);
        chk($sformatf("v%0d_sticky", i), {29'd0, cmderr_o}, {29'd0, vecs[i].exp_err});
        clear_err();
      end
    end

    // Busy errors during ACCESS; set wins over a same-cycle clear
    hart_halted_i = 1'b1;
    load_d0(32'h11111111);
    issue(32'h00230300);
    tick();
    chk("b_en", {31'd0, en}, 32'd1);
    data0_wr_en_i = 1'b1;
    data0_wdata_i = 32'hFFFFFFFF;
    cmderr_clr_i = 3'b111;
    tick();
    data0_wr_en_i = 1'b0;
    cmderr_clr_i = 3'b000;
    chk("b_err_set", {29'd0, cmderr_o}, 32'd1);
    chk("b_d0_kept", data0_o, 32'h11111111);
    issue(32'h00221005);
    chk("b_err_stay", {29'd0, cmderr_o}, 32'd1);
    chk("b_en_still", {31'd0, en}, 32'd1);
    chk("b_addr_first", {16'd0, addr}, 32'h00000300);
    dm_reg_ack_i = 1'b1;
    tick();
    dm_reg_ack_i = 1'b0;
    tick();
    chk("b_idle", {31'd0, busy_o}, 32'd0);
    chk("b_err_final", {29'd0, cmderr_o}, 32'd1);
    clear_err();

    // Timeout with no ack, then a late ack that must be ignored
    begin
      int n;
      n = 0;
      load_d0(32'h55AA55AA);
      issue(32'h00221005);
      tick();
      for (int k = 0; k < 20; k++) begin
        if (en) n++;
        else if (n > 0) break;
        tick();
      end
      chk("t_en_cycles", n, 4);
      chk("t_busy_done", {31'd0, busy_o}, 32'd1);
      chk("t_cmderr", {29'd0, cmderr_o}, 32'd3);
      dm_reg_ack_i = 1'b1;
      dm_reg_rdata_i = 32'hBAD0BAD0;
      tick();
      dm_reg_ack_i = 1'b0;
      chk("t_d0_kept", data0_o, 32'h55AA55AA);
      chk("t_idle", {31'd0, busy_o}, 32'd0);
      clear_err();
    end

    // Reset in the middle of an access
    load_d0(32'h77777777);
    issue(32'h00221005);
    tick();
    chk("r_en_pre", {31'd0, en}, 32'd1);
    reset_i = 1'b0;
    tick();
    reset_i = 1'b1;
    chk("r_en", {31'd0, en}, 32'd0);
    chk("r_busy", {31'd0, busy_o}, 32'd0);
    chk("r_d0", data0_o, 32'd0);
    chk("r_addr", {16'd0, addr}, 32'd0);
    dm_reg_ack_i = 1'b1;
    dm_reg_rdata_i = 32'h99999999;
    tick();
    dm_reg_ack_i = 1'b0;
    chk("r_late_ack_d0", data0_o, 32'd0);
    chk("r_late_ack_busy", {31'd0, busy_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
